// File: rtl/saturating_branch_predictor_if.sv
// Lookup, training and statistics signals shared between the fetch/resolve
// stages (master) and the branch predictor (slave).
interface saturating_branch_predictor_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int COUNTER_WIDTH = 2,
  parameter int HISTORY_WIDTH = 4,
  parameter int STAT_WIDTH    = 16
);
  logic                     lk_valid;
  logic [ADDRESS_WIDTH-1:0] lk_address;
  logic                     upd_valid;
  logic [ADDRESS_WIDTH-1:0] upd_address;
  logic                     upd_taken;
  logic                     upd_predicted;
  logic                     clr_stats;
  logic                     pred_valid;
  logic                     pred_taken;
  logic [COUNTER_WIDTH-1:0] pred_counter;
  logic [HISTORY_WIDTH-1:0] ghr;
  logic [STAT_WIDTH-1:0]    mispredict_count;

  modport master (
    output lk_valid, lk_address, upd_valid, upd_address, upd_taken,
           upd_predicted, clr_stats,
    input  pred_valid, pred_taken, pred_counter, ghr, mispredict_count
  );

  modport slave (
    input  lk_valid, lk_address, upd_valid, upd_address, upd_taken,
           upd_predicted, clr_stats,
    output pred_valid, pred_taken, pred_counter, ghr, mispredict_count
  );
endinterface

// File: rtl/saturating_branch_predictor.sv
// Table of saturating counters with independent lookup/train ports, optional
// gshare indexing over a global history register, and a mispredict counter.
module saturating_branch_predictor #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int COUNTER_WIDTH = 2,
  parameter int HISTORY_WIDTH = 4,
  parameter int GSHARE        = 0,
  parameter int STAT_WIDTH    = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  saturating_branch_predictor_if.slave bp
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] RESET_VAL =
    COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
  localparam logic [COUNTER_WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [STAT_WIDTH-1:0]    STAT_MAX = '1;

  logic [COUNTER_WIDTH-1:0] cnt_table [DEPTH];
  logic [HISTORY_WIDTH-1:0] ghr_q;
  logic [STAT_WIDTH-1:0]    stat_q;
  logic                     pred_valid_q;
  logic                     pred_taken_q;
  logic [COUNTER_WIDTH-1:0] pred_counter_q;

  logic [ADDRESS_WIDTH-1:0] hash;
  logic [ADDRESS_WIDTH-1:0] lk_idx;
  logic [ADDRESS_WIDTH-1:0] upd_idx;
  logic [COUNTER_WIDTH-1:0] upd_entry;
  logic [COUNTER_WIDTH-1:0] upd_next;
  logic [HISTORY_WIDTH-1:0] ghr_next;
  logic                     mispredict;

  // Both ports hash with the history held before this edge.
  assign hash    = (GSHARE != 0) ? ADDRESS_WIDTH'(ghr_q) : '0;
  assign lk_idx  = bp.lk_address ^ hash;
  assign upd_idx = bp.upd_address ^ hash;

  always_comb begin
    upd_entry = cnt_table[upd_idx];
    upd_next  = upd_entry;
    if (bp.upd_taken) begin
      if (upd_entry != MAX_VAL) upd_next = upd_entry + COUNTER_WIDTH'(1);
    end else begin
      if (upd_entry != '0) upd_next = upd_entry - COUNTER_WIDTH'(1);
    end
  end

  // Truncating {ghr, taken} drops the oldest bit, which also covers a 1-bit history.
  assign ghr_next   = HISTORY_WIDTH'({ghr_q, bp.upd_taken});
  assign mispredict = bp.upd_valid && (bp.upd_predicted != bp.upd_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_table[i] <= RESET_VAL;
    end else if (bp.upd_valid) begin
      cnt_table[upd_idx] <= upd_next;
    end
  end

  // The lookup reads the table before this edge's update lands (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_counter_q <= RESET_VAL;
    end else begin
      pred_valid_q <= bp.lk_valid;
      if (bp.lk_valid) begin
        pred_counter_q <= cnt_table[lk_idx];
        pred_taken_q   <= cnt_table[lk_idx][COUNTER_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q  <= '0;
      stat_q <= '0;
    end else begin
      if (bp.upd_valid) ghr_q <= ghr_next;
      if (bp.clr_stats) begin
        stat_q <= '0;
      end else if (mispredict && (stat_q != STAT_MAX)) begin
        stat_q <= stat_q + STAT_WIDTH'(1);
      end
    end
  end

  assign bp.pred_valid       = pred_valid_q;
  assign bp.pred_taken       = pred_taken_q;
  assign bp.pred_counter     = pred_counter_q;
  assign bp.ghr              = ghr_q;
  assign bp.mispredict_count = stat_q;
endmodule

// File: tb/tb_saturating_branch_predictor.sv
// Directed bench: one stimulus stream drives a bimodal, a gshare and a
// narrow-statistics predictor side by side.
module tb_saturating_branch_predictor;
  logic       clk;
  logic       rst_n;
  logic       lk_valid;
  logic [3:0] lk_address;
  logic       upd_valid;
  logic [3:0] upd_address;
  logic       upd_taken;
  logic       upd_predicted;
  logic       clr_stats;
  int         checks = 0;
  int         errors = 0;

  saturating_branch_predictor_if #(.ADDRESS_WIDTH(4), .COUNTER_WIDTH(2),
    .HISTORY_WIDTH(4), .STAT_WIDTH(16)) bim_if ();
  saturating_branch_predictor_if #(.ADDRESS_WIDTH(4), .COUNTER_WIDTH(2),
    .HISTORY_WIDTH(4), .STAT_WIDTH(16)) gsh_if ();
  saturating_branch_predictor_if #(.ADDRESS_WIDTH(4), .COUNTER_WIDTH(2),
    .HISTORY_WIDTH(4), .STAT_WIDTH(4)) st_if ();

  assign {bim_if.lk_valid, bim_if.lk_address, bim_if.upd_valid, bim_if.upd_address,
          bim_if.upd_taken, bim_if.upd_predicted, bim_if.clr_stats} =
         {lk_valid, lk_address, upd_valid, upd_address, upd_taken, upd_predicted, clr_stats};
  assign {gsh_if.lk_valid, gsh_if.lk_address, gsh_if.upd_valid, gsh_if.upd_address,
          gsh_if.upd_taken, gsh_if.upd_predicted, gsh_if.clr_stats} =
         {lk_valid, lk_address, upd_valid, upd_address, upd_taken, upd_predicted, clr_stats};
  assign {st_if.lk_valid, st_if.lk_address, st_if.upd_valid, st_if.upd_address,
          st_if.upd_taken, st_if.upd_predicted, st_if.clr_stats} =
         {lk_valid, lk_address, upd_valid, upd_address, upd_taken, upd_predicted, clr_stats};

  saturating_branch_predictor #(.ADDRESS_WIDTH(4), .COUNTER_WIDTH(2), .HISTORY_WIDTH(4),
    .GSHARE(0), .STAT_WIDTH(16)) dut_bim (.clk(clk), .rst_n(rst_n), .bp(bim_if));
  saturating_branch_predictor #(.ADDRESS_WIDTH(4), .COUNTER_WIDTH(2), .HISTORY_WIDTH(4),
    .GSHARE(1), .STAT_WIDTH(16)) dut_gsh (.clk(clk), .rst_n(rst_n), .bp(gsh_if));
  saturating_branch_predictor #(.ADDRESS_WIDTH(4), .COUNTER_WIDTH(2), .HISTORY_WIDTH(4),
    .GSHARE(0), .STAT_WIDTH(4)) dut_st (.clk(clk), .rst_n(rst_n), .bp(st_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge sample them, return 1ns later.
  task automatic applyStimulus(input logic lkv, input logic [3:0] lka,
                               input logic updv, input logic [3:0] upda,
                               input logic updt, input logic updp, input logic clr);
    lk_valid      = lkv;
    lk_address    = lka;
    upd_valid     = updv;
    upd_address   = upda;
    upd_taken     = updt;
    upd_predicted = updp;
    clr_stats     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lk_valid = 1'b0; lk_address = '0; upd_valid = 1'b0; upd_address = '0;
    upd_taken = 1'b0; upd_predicted = 1'b0; clr_stats = 1'b0;
    #12;
    checkOutput("rst_pred_valid",   {31'd0, bim_if.pred_valid}, 32'd0);
    checkOutput("rst_pred_counter", {30'd0, bim_if.pred_counter}, 32'd1);
    checkOutput("rst_ghr",          {28'd0, bim_if.ghr}, 32'd0);
    rst_n = 1'b1;

    // Reset values seen through a lookup
    applyStimulus(1, 4'd7, 0, 4'd0, 0, 0, 0);
    checkOutput("t1_pred_valid",   {31'd0, bim_if.pred_valid}, 32'd1);
    checkOutput("t1_pred_taken",   {31'd0, bim_if.pred_taken}, 32'd0);
    checkOutput("t1_pred_counter", {30'd0, bim_if.pred_counter}, 32'd1);
    checkOutput("t1_ghr",          {28'd0, bim_if.ghr}, 32'd0);
    checkOutput("t1_mispredicts",  {16'd0, bim_if.mispredict_count}, 32'd0);
    applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 0);
    checkOutput("idle_pred_valid", {31'd0, bim_if.pred_valid}, 32'd0);
    checkOutput("idle_hold_count", {30'd0, bim_if.pred_counter}, 32'd1);

    // Saturation at the top and bottom of entry 5
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'd0, 1, 4'd5, 1, 1, 0);
    checkOutput("t2_ghr_taken", {28'd0, bim_if.ghr}, 32'h7);
    applyStimulus(1, 4'd5, 0, 4'd0, 0, 0, 0);
    checkOutput("t2_sat_high",       {30'd0, bim_if.pred_counter}, 32'd3);
    checkOutput("t2_sat_high_taken", {31'd0, bim_if.pred_taken}, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'd0, 1, 4'd5, 0, 0, 0);
    applyStimulus(1, 4'd5, 0, 4'd0, 0, 0, 0);
    checkOutput("t2_sat_low",       {30'd0, bim_if.pred_counter}, 32'd0);
    checkOutput("t2_sat_low_taken", {31'd0, bim_if.pred_taken}, 32'd0);
    checkOutput("t2_ghr_cleared",   {28'd0, bim_if.ghr}, 32'd0);

    // Same-cycle lookup and update of entry 2
    applyStimulus(1, 4'd2, 1, 4'd2, 1, 1, 0);
    checkOutput("t3_read_before_write", {30'd0, bim_if.pred_counter}, 32'd1);
    applyStimulus(1, 4'd2, 0, 4'd0, 0, 0, 0);
    checkOutput("t3_after_write",       {30'd0, bim_if.pred_counter}, 32'd2);
    checkOutput("t3_after_write_taken", {31'd0, bim_if.pred_taken}, 32'd1);

    // Asynchronous reset between edges during back-to-back lookups
    applyStimulus(1, 4'd2, 0, 4'd0, 0, 0, 0);
    checkOutput("t6_pre_valid", {31'd0, bim_if.pred_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid",   {31'd0, bim_if.pred_valid}, 32'd0);
    checkOutput("t6_async_ghr",     {28'd0, bim_if.ghr}, 32'd0);
    checkOutput("t6_async_counter", {30'd0, bim_if.pred_counter}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1, a[3:0], 0, 4'd0, 0, 0, 0);
      checkOutput($sformatf("t6_entry_%0d", a), {30'd0, bim_if.pred_counter}, 32'd1);
    end

    // Gshare versus bimodal indexing from a clean table
    applyStimulus(0, 4'd0, 1, 4'd0, 1, 1, 0);
    applyStimulus(0, 4'd0, 1, 4'd0, 1, 1, 0);
    checkOutput("t4_gsh_ghr", {28'd0, gsh_if.ghr}, 32'h3);
    checkOutput("t4_bim_ghr", {28'd0, bim_if.ghr}, 32'h3);
    applyStimulus(1, 4'd3, 0, 4'd0, 0, 0, 0);
    checkOutput("t4_gsh_counter", {30'd0, gsh_if.pred_counter}, 32'd2);
    checkOutput("t4_gsh_taken",   {31'd0, gsh_if.pred_taken}, 32'd1);
    checkOutput("t4_bim_counter", {30'd0, bim_if.pred_counter}, 32'd1);

    // Mispredict statistics, saturation and clear priority
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'd0, 1, 4'd9, 0, 1, 0);
    checkOutput("t5_three", {28'd0, st_if.mispredict_count}, 32'd3);
    applyStimulus(0, 4'd0, 1, 4'd9, 0, 0, 0);
    applyStimulus(0, 4'd0, 1, 4'd9, 1, 1, 0);
    checkOutput("t5_correct_hold", {28'd0, st_if.mispredict_count}, 32'd3);
    for (int i = 0; i < 20; i++) applyStimulus(0, 4'd0, 1, 4'd9, 0, 1, 0);
    checkOutput("t5_saturated",  {28'd0, st_if.mispredict_count}, 32'd15);
    checkOutput("t5_wide_count", {16'd0, bim_if.mispredict_count}, 32'd23);
    applyStimulus(0, 4'd0, 1, 4'd9, 0, 1, 1);
    checkOutput("t5_clear_priority", {28'd0, st_if.mispredict_count}, 32'd0);
    checkOutput("t5_wide_clear",     {16'd0, bim_if.mispredict_count}, 32'd0);
    applyStimulus(0, 4'd0, 1, 4'd9, 1, 0, 0);
    checkOutput("t5_after_clear", {28'd0, st_if.mispredict_count}, 32'd1);

    applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/saturating_branch_predictor.md
# saturating_branch_predictor

Parametrised branch predictor: a table of 2**ADDRESS_WIDTH saturating counters with independent lookup and update ports, an optional gshare index hash over a global history register, and a saturating mispredict statistics counter. It sits beside the fetch stage. Fetch issues lookups, and the execute/branch-resolve stage issues updates. It generalises the team's one-bit predictor to N-bit counters, separate read/train ports, history hashing and accuracy tracking.

## Interface
- ADDRESS_WIDTH, 4, index bits; table depth is 2**ADDRESS_WIDTH.
- COUNTER_WIDTH, 2, bits per saturating counter; must be >= 1.
- HISTORY_WIDTH, 4, global history register bits; must be in 1..ADDRESS_WIDTH.
- GSHARE, 0; 0 selects bimodal indexing, 1 selects the gshare index.
- STAT_WIDTH, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lk_valid  in  1  lookup request.
- lk_address  in  ADDRESS_WIDTH  branch address for the lookup.
- upd_valid  in  1  resolved-branch update request.
- upd_address  in  ADDRESS_WIDTH  branch address for the update.
- upd_taken  in  1  resolved outcome.
- upd_predicted  in  1  the prediction that was made for this branch.
- clr_stats  in  1  synchronous clear of mispredict_count.
- pred_valid  out  1  prediction result valid.
- pred_taken  out  1  prediction; equals the MSB of the counter.
- pred_counter  out  COUNTER_WIDTH  raw counter value read.
- ghr  out  HISTORY_WIDTH  global history register.
- mispredict_count  out  STAT_WIDTH  count of mispredicted updates.

## Operation
- Reset state (applied immediately on rst_n low, independent of clk):
  - Every table entry = 2**(COUNTER_WIDTH-1)-1 (weakly not-taken; 0 when COUNTER_WIDTH=1).
  - ghr = 0.
  - mispredict_count = 0.
  - pred_valid = 0, pred_taken = 0.
  - pred_counter = the reset entry value.
- Index function, idx(a):
  - GSHARE=0: idx(a) = a.
  - GSHARE=1: idx(a) = a XOR zero-extend(ghr).
  - Both ports use the ghr value held before the current edge.
- Lookup (lk_valid=1): register table[idx(lk_address)] into pred_counter, its MSB into pred_taken, and set pred_valid=1.
- With lk_valid=0: pred_valid=0; pred_taken and pred_counter hold their last values.
- Update (upd_valid=1), with e = table[idx(upd_address)]:
  - upd_taken=1: e <= min(e+1, 2**COUNTER_WIDTH-1).
  - upd_taken=0: e <= max(e-1, 0).
  - No wrap-around in either direction.
  - ghr <= {ghr[HISTORY_WIDTH-2:0], upd_taken}. When HISTORY_WIDTH=1, ghr <= upd_taken.
  - ghr is shifted in both modes; it affects indexing only when GSHARE=1.
- Mispredict statistics:
  - When upd_valid=1 and upd_predicted != upd_taken, mispredict_count increments by 1.
  - It saturates at 2**STAT_WIDTH-1 and does not wrap.
  - When clr_stats=1, mispredict_count <= 0. clr_stats has priority over a same-cycle increment.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update value (read-before-write). The new value is visible to lookups from the next edge onward.
- Simultaneous lookup and update to different indices: fully independent, no stall.
- Reset mid-operation: all state returns to the reset values immediately; an in-flight pred_valid drops without waiting for a clock edge.
- Reset release: the first lookup sampled on the first rising edge after rst_n goes high is serviced.

## Timing
- Lookup latency is 1 cycle: lk_valid sampled at edge N gives pred_valid/pred_taken/pred_counter valid after edge N, for one cycle per request.
- Back-to-back lookups on every cycle are supported, giving 1 prediction per cycle.
- An update issued at edge N commits at edge N; the counter and ghr are visible to lookups sampled at edge N+1.
- mispredict_count updates at the same edge as its triggering update.
- No handshake backpressure exists; both ports are always ready.

## Test plan
Unless stated, tests use default parameters with GSHARE=0.
1. **Reset values:** pulse rst_n low, release, lookup addr 7 -> pred_valid=1 one cycle later, pred_taken=0, pred_counter=1, ghr=0, mispredict_count=0.
2. **Saturation:**
   - 3 taken updates to addr 5, then lookup -> pred_counter=3, pred_taken=1 (no wrap past 3).
   - Then 4 not-taken updates -> pred_counter=0, pred_taken=0 (no wrap below 0).
3. **Same-cycle collision:** entry 2 = 1; in one cycle, taken update to addr 2 plus lookup of addr 2 -> pred_counter=1. Lookup next cycle -> pred_counter=2, pred_taken=1.
4. **Gshare indexing (GSHARE=1):** from reset, two taken updates to addr 0 -> ghr=4'b0011. Lookup addr 3 reads entry 0: pred_counter=2 (entry 0 after one increment from the update issued with ghr=0). Same lookup with GSHARE=0 -> pred_counter=1.
5. **Mispredict counting (STAT_WIDTH=4):**
   - 3 updates with upd_predicted=1, upd_taken=0 -> mispredict_count=3.
   - Correct predictions -> unchanged.
   - 20 more mispredicts -> 15 (saturated).
   - clr_stats together with a mispredict -> 0.
6. **Asynchronous reset mid-stream:** during back-to-back lookups with pred_valid=1 and trained entries, drop rst_n between edges -> pred_valid=0, ghr=0 immediately. After release, every address returns pred_counter=1.
